// File: rtl/hartslag_filter_if.sv
// rtl/hartslag_filter_if.sv - sensor in / conditioned beat outputs bundle
interface hartslag_filter_if;
    logic       sensor;
    logic       niveau;
    logic       puls;
    logic       geen_slag;
    logic [7:0] slag_teller;

    // Filter side: consumes the raw sensor, produces the conditioned outputs
    modport slave (
        input  sensor,
        output niveau,
        output puls,
        output geen_slag,
        output slag_teller
    );

    // Environment side: drives the raw sensor, observes the outputs
    modport master (
        output sensor,
        input  niveau,
        input  puls,
        input  geen_slag,
        input  slag_teller
    );
endinterface

// File: rtl/hartslag_filter.sv
// rtl/hartslag_filter.sv - heartbeat sensor synchroniser, debouncer and beat qualifier
module hartslag_filter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRACT_CYCLES  = 12500000,
    parameter int TIMEOUT_CYCLES  = 150000000
) (
    input  logic              clk,
    input  logic              reset,
    hartslag_filter_if.slave  hif
);
    localparam logic [27:0] DB_LAST  = 28'(DEBOUNCE_CYCLES - 1);
    localparam logic [27:0] REF_LAST = 28'(REFRACT_CYCLES - 1);
    localparam logic [27:0] TO_LAST  = 28'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        LAAG       = 2'd0,
        REFRACT    = 2'd1,
        WACHT_LAAG = 2'd2
    } state_t;

    state_t      state;
    logic        s_meta;
    logic        s_sync;
    logic        niveau;
    logic        niveau_d;
    logic [27:0] db_cnt;
    logic [27:0] ref_cnt;
    logic [27:0] to_cnt;
    logic        puls;
    logic        geen_slag;
    logic [7:0]  slag_teller;
    logic        accept;

    // A beat is accepted only on a fresh rising edge of the debounced level while idle
    assign accept = (state == LAAG) && niveau && !niveau_d;

    assign hif.niveau      = niveau;
    assign hif.puls        = puls;
    assign hif.geen_slag   = geen_slag;
    assign hif.slag_teller = slag_teller;

    // Two-flop synchroniser; the only logic that samples the raw sensor line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            s_meta <= hif.sensor;
            s_sync <= s_meta;
        end
    end

    // Debouncer: the level follows the synced input only after it has differed long enough
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            niveau <= 1'b0;
            db_cnt <= '0;
        end else if (s_sync == niveau) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            niveau <= ~niveau;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 28'd1;
        end
    end

    // Beat FSM: accept, sit out the refractory window, then require a low level before re-arming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LAAG;
            niveau_d    <= 1'b0;
            ref_cnt     <= '0;
            puls        <= 1'b0;
            slag_teller <= '0;
        end else begin
            niveau_d <= niveau;
            puls     <= 1'b0;
            case (state)
                LAAG: begin
                    if (accept) begin
                        puls    <= 1'b1;
                        ref_cnt <= '0;
                        if (slag_teller != 8'hFF)
                            slag_teller <= slag_teller + 8'd1;
                        state   <= REFRACT;
                    end
                end
                REFRACT: begin
                    if (ref_cnt == REF_LAST)
                        state <= WACHT_LAAG;
                    else
                        ref_cnt <= ref_cnt + 28'd1;
                end
                WACHT_LAAG: begin
                    if (!niveau)
                        state <= LAAG;
                end
                default: state <= LAAG;
            endcase
        end
    end

    // Loss-of-beat timer; an accepted beat in the expiry cycle takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt    <= '0;
            geen_slag <= 1'b0;
        end else if (accept) begin
            to_cnt    <= '0;
            geen_slag <= 1'b0;
        end else if (to_cnt == TO_LAST) begin
            geen_slag <= 1'b1;
        end else begin
            to_cnt <= to_cnt + 28'd1;
        end
    end
endmodule
